// File: rtl/ser_pkg.sv
// ser_pkg: shared state type and widths for the 4-bit serializer
package ser_pkg;
    localparam int WORD_BITS = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/ser_sel_cnt.sv
// ser_sel_cnt: 2-bit wrapping bit-select counter with sync clear and enable
module ser_sel_cnt
    import ser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] cnt
);
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/serializer_ctrl.sv
// serializer_ctrl: double-buffered 4-bit word serializer driving a 4:1 mux
module serializer_ctrl
    import ser_pkg::*;
#(
    parameter bit LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_BITS-1:0] mux_data,
    output logic [SEL_W-1:0]     mux_sel,
    output logic                 mux_en,
    output logic                 word_start,
    output logic                 underrun
);
    state_t state, state_nxt;
    logic [WORD_BITS-1:0] cur_word, nxt_word;
    logic nxt_valid, accept, shift, last;
    logic [SEL_W-1:0] cnt;
    ser_sel_cnt u_cnt (.clk(clk), .rst(rst), .clr(!shift), .en(shift), .cnt(cnt));
    assign shift = state == SHIFT;
    assign last = shift && (&cnt);
    assign in_ready = !shift || !nxt_valid;
    assign accept = in_valid && in_ready;
    assign mux_en = shift;
    assign mux_data = cur_word;
    assign mux_sel = shift ? (LSB_FIRST ? cnt : ~cnt) : '0;
    assign word_start = shift && cnt == '0;
    assign underrun = last && !nxt_valid && !accept;
    always_comb
        state_nxt = shift ? (underrun ? IDLE : SHIFT) : (accept ? SHIFT : IDLE);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    // an empty next buffer at the last bit lets a fresh word go straight to cur_word
    always_ff @(posedge clk)
        if (rst) begin
            cur_word <= '0;
            nxt_word <= '0;
            nxt_valid <= 1'b0;
        end else if (!shift || (last && !nxt_valid)) begin
            if (accept) cur_word <= in_data;
        end else if (last) begin
            cur_word <= nxt_word;
            nxt_valid <= accept;
            if (accept) nxt_word <= in_data;
        end else if (accept) begin
            nxt_word <= in_data;
            nxt_valid <= 1'b1;
        end
endmodule

// File: tb/tb_serializer_ctrl.sv
// tb_serializer_ctrl: queue-model check of both bit orders plus directed literal cases
module tb_serializer_ctrl;
    logic clk = 0, rst = 1, in_valid = 0;
    logic [3:0] in_data = 0;
    logic l_ready, l_en, l_ws, l_ur, m_ready, m_en, m_ws, m_ur;
    logic [3:0] l_data, m_data;
    logic [1:0] l_sel, m_sel;
    int checks = 0, errors = 0, en_cycles = 0, ur_cnt = 0, pos = 0;
    logic [3:0] q[$];
    bit e;

    serializer_ctrl #(.LSB_FIRST(1)) u_lsb (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .mux_data(l_data), .mux_sel(l_sel), .mux_en(l_en), .word_start(l_ws), .underrun(l_ur));
    serializer_ctrl #(.LSB_FIRST(0)) u_msb (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .mux_data(m_data), .mux_sel(m_sel), .mux_en(m_en), .word_start(m_ws), .underrun(m_ur));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: q holds accepted words not yet fully emitted, q[0] is on the mux at bit pos
    always @(posedge clk)
        if (rst) begin
            q.delete();
            pos = 0;
        end else begin
            e = in_valid && q.size() < 2;
            if (q.size() > 0) begin
                if (pos == 3) begin
                    void'(q.pop_front());
                    pos = 0;
                end else pos++;
            end
            if (e) q.push_back(in_data);
        end

    always @(negedge clk)
        if (!rst) begin
            chk("ready_l", l_ready, q.size() < 2);
            chk("ready_m", m_ready, q.size() < 2);
            chk("en_l", l_en, q.size() > 0);
            chk("en_m", m_en, q.size() > 0);
            chk("sel_l", l_sel, q.size() > 0 ? pos : 0);
            chk("sel_m", m_sel, q.size() > 0 ? 3 - pos : 0);
            chk("ws_l", l_ws, q.size() > 0 && pos == 0);
            chk("ws_m", m_ws, q.size() > 0 && pos == 0);
            chk("ur_l", l_ur, q.size() == 1 && pos == 3 && !in_valid);
            chk("ur_m", m_ur, q.size() == 1 && pos == 3 && !in_valid);
            if (q.size() > 0) begin
                chk("data_l", l_data, q[0]);
                chk("data_m", m_data, q[0]);
                chk("bit_l", l_data[l_sel], q[0][pos]);
                chk("bit_m", m_data[m_sel], q[0][3-pos]);
            end
            if (l_en) en_cycles++;
            if (l_ur) ur_cnt++;
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] w);
        bit ok = 0;
        in_valid = 1;
        in_data = w;
        repeat (20) if (!ok) begin
            @(negedge clk);
            ok = l_ready;
            step();
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        bit done = 0;
        repeat (40) if (!done) begin
            @(negedge clk);
            done = !l_en;
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    // lb/mb: expected serial bit in cycle i for the LSB-first / MSB-first instance
    task automatic single(input logic [3:0] w, input logic [3:0] lb, input logic [3:0] mb);
        in_valid = 1;
        in_data = w;
        @(negedge clk);
        chk("lit_ready", l_ready, 1);
        step();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_sel_l", l_sel, i);
            chk("lit_sel_m", m_sel, 3 - i);
            chk("lit_data", l_data, w);
            chk("lit_ws", l_ws, i == 0);
            chk("lit_ur", l_ur, i == 3);
            chk("lit_bit_l", l_data[l_sel], lb[i]);
            chk("lit_bit_m", m_data[m_sel], mb[i]);
            step();
        end
        @(negedge clk);
        chk("lit_idle_en", l_en, 0);
        step();
    endtask

    initial begin
        int dens = 50;
        step();
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_en", l_en, 0);
        chk("rst_sel", l_sel, 0);
        chk("rst_data", l_data, 0);
        chk("rst_ws", l_ws, 0);
        chk("rst_ur", l_ur, 0);
        chk("rst_ready", l_ready, 1);
        step();
        single(4'hA, 4'b1010, 4'b0101);
        single(4'h1, 4'b0001, 4'b1000);
        en_cycles = 0;
        ur_cnt = 0;
        send(4'h3);
        send(4'hC);
        send(4'h5);
        drain();
        chk("b2b_en_cycles", en_cycles, 12);
        chk("b2b_underruns", ur_cnt, 1);
        step();
        en_cycles = 0;
        ur_cnt = 0;
        send(4'h9);
        step();
        step();
        step();
        send(4'h6);
        drain();
        chk("late_en_cycles", en_cycles, 8);
        chk("late_underruns", ur_cnt, 1);
        step();
        send(4'h5);
        send(4'h6);
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("mid_rst_en", l_en, 0);
        chk("mid_rst_ready", l_ready, 1);
        chk("mid_rst_ur", l_ur, 0);
        step();
        single(4'hA, 4'b1010, 4'b0101);
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) dens = $urandom_range(10, 100);
            rst = $urandom_range(0, 199) == 0;
            in_valid = $urandom_range(1, 100) <= dens;
            in_data = 4'($urandom);
            step();
        end
        rst = 0;
        in_valid = 0;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serializer_ctrl.md
SERIALIZER_CTRL -- requirements
Module: serializer_ctrl

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1, meaning 1 = emit bit 0 first and 0 = emit bit 3 first.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data  input  4  parallel word to serialize.
REQ-005 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-006 The block SHALL have port in_ready  output  1  block accepts in_data this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-007 The block SHALL have port mux_data  output  4  word driven onto the 4:1 mux data inputs.
REQ-008 The block SHALL have port mux_sel  output  2  mux select.
REQ-009 The block SHALL have port mux_en  output  1  mux enable; the mux output is 0 when this is low.
REQ-010 The block SHALL have port word_start  output  1  pulse marking the first bit of each word.
REQ-011 The block SHALL have port underrun  output  1  one-cycle pulse when the stream ends because no next word is available.

Function
REQ-012 The block SHALL hold registers cur_word, nxt_word, nxt_valid, a 2-bit counter cnt, and a state in {IDLE, SHIFT}.
REQ-013 In IDLE the block SHALL drive mux_en=0, mux_sel=0, word_start=0 and in_ready=1.
REQ-014 In IDLE, an accept in cycle N SHALL load cur_word<=in_data, set cnt<=0 and enter SHIFT, so that bit 0 (or bit 3) is selected in cycle N+1.
REQ-015 In SHIFT the block SHALL drive mux_en=1, mux_data=cur_word, and mux_sel=cnt when LSB_FIRST=1 or mux_sel=3-cnt when LSB_FIRST=0.
REQ-016 In SHIFT, word_start SHALL be 1 exactly when cnt==0.
REQ-017 In SHIFT, cnt SHALL increment by 1 each cycle and wrap from 3 to 0; every word occupies exactly 4 consecutive cycles.
REQ-018 In SHIFT, in_ready SHALL equal !nxt_valid, and an accept SHALL load nxt_word and set nxt_valid, except as stated in REQ-020.
REQ-019 At cnt==3 with nxt_valid=1, the block SHALL set cur_word<=nxt_word and stay in SHIFT; nxt_valid SHALL clear unless a word is accepted in the same cycle, in which case nxt_word<=in_data and nxt_valid stays 1.
REQ-020 At cnt==3 with nxt_valid=0 and an accept in the same cycle, the block SHALL load cur_word<=in_data directly and stay in SHIFT with no gap cycle.
REQ-021 At cnt==3 with nxt_valid=0 and no accept, the block SHALL enter IDLE and pulse underrun for that cycle.
REQ-022 Back-to-back words SHALL produce a gapless bit stream at one bit per clock.
REQ-023 mux_data SHALL be stable for all 4 cycles of a word.
REQ-024 in_data SHALL be ignored when in_ready=0.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set state=IDLE, cnt=0, cur_word=0, nxt_word=0 and nxt_valid=0.
REQ-026 After reset the outputs SHALL be mux_en=0, mux_sel=0, mux_data=0, word_start=0, underrun=0 and in_ready=1.
REQ-027 A reset asserted mid-word SHALL discard both buffered words with no underrun pulse.
REQ-028 The first cycle after reset release SHALL behave as IDLE.

Structure
REQ-029 The package ser_pkg SHALL contain the state type {IDLE, SHIFT} and constants WORD_BITS=4 and SEL_W=2.
REQ-030 The select counter SHALL be the sub-module ser_sel_cnt, a 2-bit wrapping counter with sync clear and enable.
REQ-031 serializer_ctrl SHALL contain the state register, the buffers and the handshake logic; no other sub-modules.

Verification
REQ-032 Single word: reset, then send 0xA (LSB_FIRST=1) -> mux_sel 0,1,2,3 and mux_data=0xA in cycles N+1..N+4; serial bits 0,1,0,1; word_start at N+1; underrun at N+4; IDLE at N+5.
REQ-033 Back-to-back: in_valid held high with words 0x3, 0xC, 0x5 -> 12 consecutive mux_en=1 cycles; word_start every 4th cycle; no underrun until after the last word.
REQ-034 Backpressure: offer 3 words while the first is shifting -> in_ready=0 after nxt fills, returns to 1 in the cycle after cnt==3; no word lost or duplicated.
REQ-035 Late refill: offer the 2nd word exactly at cnt==3 of the 1st with nxt empty -> seamless continuation, underrun never pulses.
REQ-036 MSB first: LSB_FIRST=0 with word 0x1 -> mux_sel 3,2,1,0; serial bits 0,0,0,1.
REQ-037 Mid-word reset: assert rst at cnt==1 with nxt_valid=1 -> next cycle mux_en=0, in_ready=1, underrun=0; a new word then starts cleanly from bit 0.
